// File: rtl/morse_key_capture.sv
// Morse key capture: synchronize, debounce, time elements in dot units and publish characters as a status word.
// Optional char_strobe output is enabled by defining MORSE_CHAR_STROBE_EN.
module morse_key_capture #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int UNIT_CYC     = 5000000,
    parameter int MAX_ELEM     = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        key_n,
    output logic [31:0] key_word,
    output logic        key_led
`ifdef MORSE_CHAR_STROBE_EN
    ,
    output logic        char_strobe
`endif
);

    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam int CW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYC - 1);
    localparam logic [2:0]    MAX_LEN  = 3'(MAX_ELEM);

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    logic [1:0]    sync_reg;
    logic [DW-1:0] deb_cnt_reg;
    logic          led_reg;
    logic [CW-1:0] cyc_cnt_reg;
    logic [3:0]    unit_cnt_reg;
    state_t        state_reg;
    logic [5:0]    pattern_reg;
    logic [2:0]    count_reg;
    logic          ovf_reg;
    logic [2:0]    out_len_reg;
    logic [5:0]    out_pat_reg;
    logic          out_ovf_reg;
    logic          word_gap_reg;
    logic [7:0]    seq_reg;
    logic          strobe_reg;

    logic pressed;
    logic flip;
    logic press_evt;
    logic release_evt;
    logic tick;

    assign pressed     = ~sync_reg[1];
    assign flip        = (pressed != led_reg) && (deb_cnt_reg == DEB_LAST);
    assign press_evt   = flip && !led_reg;
    assign release_evt = flip && led_reg;
    assign tick        = (cyc_cnt_reg == CYC_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_reg    <= 2'b11;
            deb_cnt_reg <= '0;
            led_reg     <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], key_n};
            if (pressed != led_reg) begin
                if (deb_cnt_reg == DEB_LAST) begin
                    led_reg     <= ~led_reg;
                    deb_cnt_reg <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 1'b1;
                end
            end else begin
                deb_cnt_reg <= '0;
            end
        end
    end

    // Unit timing restarts on every accepted key edge so presses and gaps are measured from their start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cyc_cnt_reg  <= '0;
            unit_cnt_reg <= 4'd0;
        end else if (flip) begin
            cyc_cnt_reg  <= '0;
            unit_cnt_reg <= 4'd0;
        end else if (tick) begin
            cyc_cnt_reg <= '0;
            if (unit_cnt_reg != 4'd15) begin
                unit_cnt_reg <= unit_cnt_reg + 4'd1;
            end
        end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            pattern_reg  <= 6'd0;
            count_reg    <= 3'd0;
            ovf_reg      <= 1'b0;
            out_len_reg  <= 3'd0;
            out_pat_reg  <= 6'd0;
            out_ovf_reg  <= 1'b0;
            word_gap_reg <= 1'b0;
            seq_reg      <= 8'd0;
            strobe_reg   <= 1'b0;
        end else begin
            strobe_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (press_evt) begin
                        state_reg <= PRESS;
                    end
                end
                PRESS: begin
                    if (release_evt) begin
                        if (count_reg < MAX_LEN) begin
                            pattern_reg[count_reg] <= (unit_cnt_reg >= 4'd2);
                            count_reg              <= count_reg + 3'd1;
                        end else begin
                            ovf_reg <= 1'b1;
                        end
                        state_reg <= GAP;
                    end
                end
                GAP: begin
                    // A press landing on the commit tick still commits first; it then opens a new character.
                    if (tick && unit_cnt_reg == 4'd2) begin
                        out_len_reg  <= count_reg;
                        out_pat_reg  <= pattern_reg;
                        out_ovf_reg  <= ovf_reg;
                        word_gap_reg <= 1'b0;
                        seq_reg      <= seq_reg + 8'd1;
                        strobe_reg   <= 1'b1;
                        pattern_reg  <= 6'd0;
                        count_reg    <= 3'd0;
                        ovf_reg      <= 1'b0;
                    end else if (tick && unit_cnt_reg == 4'd6) begin
                        word_gap_reg <= 1'b1;
                        state_reg    <= IDLE;
                    end
                    if (press_evt) begin
                        state_reg <= PRESS;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign key_word = {led_reg, word_gap_reg, 6'd0, seq_reg, 6'd0,
                       out_ovf_reg, out_pat_reg, out_len_reg};
    assign key_led  = led_reg;

`ifdef MORSE_CHAR_STROBE_EN
    assign char_strobe = strobe_reg;
`else
    logic unused_strobe;
    assign unused_strobe = strobe_reg;
`endif

endmodule

// File: tb/tb_morse_key_capture.sv
// Directed bench for morse_key_capture with DEBOUNCE_CYC=4, UNIT_CYC=10 (one unit = 10 key cycles).
module tb_morse_key_capture;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        key_n = 1'b1;
    logic [31:0] key_word;
    logic        key_led;
    int          checks = 0;
    int          errors = 0;

`ifdef MORSE_CHAR_STROBE_EN
    logic char_strobe;
    int   strobe_cnt = 0;
    always @(posedge clk) begin
        if (char_strobe) strobe_cnt <= strobe_cnt + 1;
    end
`endif

    morse_key_capture #(
        .DEBOUNCE_CYC(4),
        .UNIT_CYC    (10),
        .MAX_ELEM    (6)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_n      (key_n),
        .key_word   (key_word),
        .key_led    (key_led)
`ifdef MORSE_CHAR_STROBE_EN
        ,
        .char_strobe(char_strobe)
`endif
    );

    always #5 clk = ~clk;

    // Hold key_n at v for exactly n rising edges; returns just after the last edge.
    task automatic hold(input logic v, input int n);
        key_n = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dot_char();
        hold(1'b0, 10);
        hold(1'b1, 40);
    endtask

    task automatic check_word(input string name, input logic [31:0] exp);
        @(negedge clk);
        checks++;
        if (key_word !== exp) begin
            errors++;
            $display("FAIL %s: key_word=%08h expected %08h", name, key_word, exp);
        end else begin
            $display("ok   %s: key_word=%08h", name, key_word);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            key_n = ~key_n;
            @(posedge clk);
            #1;
        end
        key_n   = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (key_word !== 32'h0 || key_led !== 1'b0) begin
            errors++;
            $display("FAIL reset: key_word=%08h key_led=%b expected 00000000/0", key_word, key_led);
        end else begin
            $display("ok   reset: key_word=%08h key_led=%b", key_word, key_led);
        end
        @(posedge clk);
        #1;
        hold(1'b1, 8);
        check_word("reset_idle", 32'h0);
    endtask

    task automatic test_glitch();
        logic seen;
        seen  = 1'b0;
        key_n = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) key_n = 1'b1;
            @(negedge clk);
            if (key_led) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL glitch_led: key_led rose=%b expected 0", seen);
        end else begin
            $display("ok   glitch_led: key_led stayed 0");
        end
        check_word("glitch_word", 32'h0);
    endtask

    task automatic test_letter_a();
        hold(1'b0, 10);
        hold(1'b1, 10);
        hold(1'b0, 30);
        hold(1'b1, 40);
        check_word("letter_a_commit", 32'h0001_0012);
        hold(1'b1, 38);
        check_word("letter_a_wordgap", 32'h4001_0012);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 7; i++) begin
            hold(1'b0, 10);
            if (i < 6) hold(1'b1, 10);
        end
        hold(1'b1, 40);
        check_word("overflow", 32'h0002_0206);
    endtask

    task automatic test_long_press();
        hold(1'b0, 200);
        hold(1'b1, 40);
        check_word("long_press_dash", 32'h0003_0009);
    endtask

    task automatic test_back_to_back();
        // Release lasts exactly 3 units so the next press lands on the commit tick.
        hold(1'b0, 10);
        hold(1'b1, 30);
        hold(1'b0, 10);
        @(negedge clk);
        checks++;
        if (key_word !== 32'h8004_0001 || key_led !== 1'b1) begin
            errors++;
            $display("FAIL simul_commit: key_word=%08h key_led=%b expected 80040001/1", key_word, key_led);
        end else begin
            $display("ok   simul_commit: key_word=%08h", key_word);
        end
        @(posedge clk);
        #1;
        hold(1'b1, 40);
        check_word("simul_next_char", 32'h0005_0001);
    endtask

    task automatic test_reset_mid_char();
`ifdef MORSE_CHAR_STROBE_EN
        int base;
`endif
        hold(1'b0, 10);
        hold(1'b1, 10);
        hold(1'b0, 15);
        reset_n = 1'b0;
        key_n   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (key_word !== 32'h0 || key_led !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: key_word=%08h key_led=%b expected 00000000/0", key_word, key_led);
        end else begin
            $display("ok   reset_mid: key_word=%08h", key_word);
        end
        @(posedge clk);
        #1;
`ifdef MORSE_CHAR_STROBE_EN
        base = strobe_cnt;
`endif
        dot_char();
        check_word("reset_mid_next", 32'h0001_0001);
`ifdef MORSE_CHAR_STROBE_EN
        checks++;
        if (strobe_cnt - base !== 1) begin
            errors++;
            $display("FAIL strobe_count: pulses=%0d expected 1", strobe_cnt - base);
        end else begin
            $display("ok   strobe_count: pulses=%0d", strobe_cnt - base);
        end
`endif
    endtask

    task automatic test_seq_wrap();
        for (int i = 0; i < 254; i++) begin
            dot_char();
        end
        check_word("seq_255", 32'h00FF_0001);
        dot_char();
        check_word("seq_wrap_0", 32'h0000_0001);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_letter_a();
        test_overflow();
        test_long_press();
        test_back_to_back();
        test_reset_mid_char();
        test_seq_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
